// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared types and constants for the FIFO read-side
// drain engine.
//   state_e    : drain state machine encoding (IDLE / RUN / STOP)
//   STAT_WIDTH : width of the WordCnt / StallCnt statistics counters
//   fcnt_w()   : frame counter width, max(1, clog2(frame_len))
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  localparam int STAT_WIDTH = 32;

  function automatic int fcnt_w(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: bundles the FIFO read port, the output stream and the
// control/stat signals of fifo_rd_stream.
//   master : drain engine side (drives FifoRen, Out*, stats)
//   slave  : environment side (FIFO, consumer, control)
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);
  logic                  Enable;
  logic                  Flush;
  logic                  FifoEmpty;
  logic [DATA_WIDTH-1:0] FifoRdData;
  logic                  FifoRen;
  logic                  OutValid;
  logic [DATA_WIDTH-1:0] OutData;
  logic                  OutLast;
  logic                  OutReady;
  logic [STAT_WIDTH-1:0] WordCnt;
  logic [STAT_WIDTH-1:0] StallCnt;

  modport master (
    input  Enable, Flush, FifoEmpty, FifoRdData, OutReady,
    output FifoRen, OutValid, OutData, OutLast, WordCnt, StallCnt
  );

  modport slave (
    output Enable, Flush, FifoEmpty, FifoRdData, OutReady,
    input  FifoRen, OutValid, OutData, OutLast, WordCnt, StallCnt
  );
endinterface

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry skid buffer between the FIFO pop path and the
// registered output stream.
//   Clk, Rstb  : clock, async active-low reset
//   push/push_data : write a word (never asserted while count==2)
//   pop        : head word consumed (never asserted while count==0)
//   flush      : drop all entries; wins over push/pop
//   count      : occupancy 0..2
//   head_data  : oldest entry
module fifo_rd_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rstb,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] tail_data;

  always_ff @(posedge Clk or negedge Rstb) begin
    if (!Rstb) begin
      count     <= 2'd0;
      head_data <= '0;
      tail_data <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= push_data;
            count     <= 2'd1;
          end else if (count == 2'd1) begin
            tail_data <= push_data;
            count     <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_data <= tail_data;
            count     <= 2'd1;
          end else if (count == 2'd1) begin
            count <= 2'd0;
          end
        end
        // Only reachable with count==1: the new word replaces the departing head.
        2'b11: begin
          if (count == 2'd1) head_data <= push_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a first-word-fall-through FIFO read port into a
// registered valid/ready stream with frame-boundary marking (OutLast on
// word FRAME_LEN-1 of every frame).
//   Clk, Rstb : reader-domain clock, async active-low reset
//   bus       : fifo_rd_stream_if.master (Enable, Flush, FIFO port,
//               OutValid/OutData/OutLast/OutReady, WordCnt/StallCnt)
// Optional: define FIFO_RD_STREAM_STATS_EN to build the saturating
// WordCnt/StallCnt counters; otherwise both ports read 0.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4
) (
  input  logic              Clk,
  input  logic              Rstb,
  fifo_rd_stream_if.master  bus
);

  localparam int             FCW        = fcnt_w(FRAME_LEN);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);

  state_e                state, state_nxt;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] head_data;
  logic [FCW-1:0]        frame_cnt;
  logic                  push, pop, out_valid;

  // Pop path never looks at OutReady, so consumer timing stays off the FIFO.
  // Rstb gating keeps the FIFO untouched while held in reset.
  assign push = Rstb & bus.Enable & ~bus.FifoEmpty & ~bus.Flush
              & (count != 2'd2) & (state != STOP);
  assign out_valid = (count != 2'd0) & ~bus.Flush;
  assign pop       = out_valid & bus.OutReady;

  assign bus.FifoRen  = push;
  assign bus.OutValid = out_valid;
  assign bus.OutData  = head_data;
  assign bus.OutLast  = out_valid & (frame_cnt == FRAME_LAST);

  fifo_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .Clk       (Clk),
    .Rstb      (Rstb),
    .push      (push),
    .push_data (bus.FifoRdData),
    .pop       (pop),
    .flush     (bus.Flush),
    .count     (count),
    .head_data (head_data)
  );

  always_ff @(posedge Clk or negedge Rstb) begin
    if (!Rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.Flush) begin
      state_nxt = bus.Enable ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: if (bus.Enable) state_nxt = RUN;
        RUN:  if (!bus.Enable) state_nxt = STOP;
        // Stay until the buffer is empty so no accepted word is stranded.
        STOP: begin
          if (count == 2'd0)   state_nxt = IDLE;
          else if (bus.Enable) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rstb) begin
    if (!Rstb)           frame_cnt <= '0;
    else if (bus.Flush)  frame_cnt <= '0;
    else if (pop)        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STAT_WIDTH-1:0] word_cnt, stall_cnt;

  // Saturating; Flush deliberately leaves the history intact.
  always_ff @(posedge Clk or negedge Rstb) begin
    if (!Rstb) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (word_cnt != '1))
        word_cnt <= word_cnt + 1'b1;
      if (out_valid && !bus.OutReady && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.WordCnt  = word_cnt;
  assign bus.StallCnt = stall_cnt;
`else
  assign bus.WordCnt  = '0;
  assign bus.StallCnt = '0;
`endif

endmodule
